// File: rtl/pe_fu_pkg.sv
// Shared types for the PE functional unit: opcode set, carry FSM states, operand channel indices.
package pe_fu_pkg;

  localparam int unsigned FU_OP_W = 5;
  localparam int unsigned NUM_CH  = 3;

  // Operand channel positions within in_valid / in_data / fu_ready
  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_D = 2;

  typedef enum logic [FU_OP_W-1:0] {
    OP_NOP    = 5'd0,
    OP_ADD    = 5'd1,
    OP_SUB    = 5'd2,
    OP_AND    = 5'd3,
    OP_OR     = 5'd4,
    OP_XOR    = 5'd5,
    OP_SHL    = 5'd6,
    OP_SHR    = 5'd7,
    OP_SRA    = 5'd8,
    OP_LTU    = 5'd9,
    OP_LTS    = 5'd10,
    OP_EQ     = 5'd11,
    OP_MUL    = 5'd12,
    OP_STEERT = 5'd13,
    OP_STEERF = 5'd14,
    OP_MERGE  = 5'd15,
    OP_CARRY  = 5'd16
  } fu_op_e;

  typedef enum logic {
    CARRY_INIT = 1'b0,
    CARRY_LOOP = 1'b1
  } carry_state_e;

endpackage

// File: rtl/pe_fu_mul_pipe.sv
// Fixed-latency multiplier: low DATA_WIDTH bits of a*b, delivered MUL_LAT-1 cycles
// after in_valid so that the FU output register adds the final cycle.
// Ports: clk/rst, flush (drop everything in flight), in_valid/a/b (launch),
//        res_valid/res_data (result for the output register), busy (any stage occupied).
module pe_fu_mul_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] product;
  assign product = a * b;

  generate
    if (MUL_LAT <= 1) begin : g_comb
      // Single-cycle multiply: the output register is the only stage
      assign res_valid = in_valid & ~flush;
      assign res_data  = product;
      assign busy      = 1'b0;
    end else begin : g_pipe
      localparam int unsigned NST = MUL_LAT - 1;

      logic [NST-1:0]        vld_q, vld_d;
      logic [DATA_WIDTH-1:0] dat_q [NST];
      logic [DATA_WIDTH-1:0] dat_d [NST];

      // Valid/data shift chain; flush kills every stage
      always_comb begin
        vld_d    = '0;
        dat_d    = '{default: '0};
        vld_d[0] = in_valid;
        dat_d[0] = product;
        for (int i = 1; i < int'(NST); i++) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
        if (flush) vld_d = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < int'(NST); i++) dat_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign res_valid = vld_q[NST-1];
      assign res_data  = dat_q[NST-1];
      assign busy      = |vld_q;
    end
  endgenerate

endmodule

// File: rtl/pe_fu_dfx.sv
// RipTide PE functional unit: ALU, pipelined multiply, and dataflow steer/merge/carry.
// Ports: clk/rst; cfg_valid/cfg_op/cfg_imm_en/cfg_imm load the opcode, cfgd shows it is armed;
//        clear aborts in-flight work; in_valid/in_data (A,B,D) with per-channel fu_ready;
//        fu_out/fu_valid with out_ready backpressure; fu_alloc on result commit, fu_done on drain.
module pe_fu_dfx
  import pe_fu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_LAT    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [4:0]              cfg_op,
  input  logic                    cfg_imm_en,
  input  logic [DATA_WIDTH-1:0]   cfg_imm,
  output logic                    cfgd,
  input  logic                    clear,
  input  logic [2:0]              in_valid,
  input  logic [3*DATA_WIDTH-1:0] in_data,
  output logic [2:0]              fu_ready,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   fu_out,
  output logic                    fu_valid,
  output logic                    fu_alloc,
  output logic                    fu_done
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  fu_op_e                op_q, op_d;
  logic                  imm_en_q, imm_en_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  cfgd_q, cfgd_d;
  carry_state_e          carry_q, carry_d;
  logic                  fu_valid_q, fu_valid_d;
  logic [DATA_WIDTH-1:0] fu_out_q, fu_out_d;

  logic [DATA_WIDTH-1:0] a, b_val, d_word, alu_res, res, mul_res_data;
  logic [SHW-1:0]        shamt;
  logic                  a_v, b_ok, d_v, d_sel;
  logic                  slot_free, can_fire, fire, produce, mul_go;
  logic                  mul_res_valid, mul_busy, cfg_accept;
  logic [2:0]            req;
  logic                  unused_d;

  // Operand views; B comes from the immediate when configured so
  assign a        = in_data[CH_A*DATA_WIDTH +: DATA_WIDTH];
  assign d_word   = in_data[CH_D*DATA_WIDTH +: DATA_WIDTH];
  assign b_val    = imm_en_q ? imm_q : in_data[CH_B*DATA_WIDTH +: DATA_WIDTH];
  assign a_v      = in_valid[CH_A];
  assign d_v      = in_valid[CH_D];
  assign b_ok     = imm_en_q | in_valid[CH_B];
  assign d_sel    = d_word[0];
  assign unused_d = ^d_word[DATA_WIDTH-1:1];
  assign shamt    = b_val[SHW-1:0];

  assign slot_free  = ~fu_valid_q | out_ready;
  assign can_fire   = cfgd_q & (op_q != OP_NOP) & slot_free & ~mul_busy & ~clear;
  assign cfg_accept = cfg_valid & ~clear & ~fu_valid_q & ~mul_busy;

  // Single-cycle ALU datapath
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD: alu_res = a + b_val;
      OP_SUB: alu_res = a - b_val;
      OP_AND: alu_res = a & b_val;
      OP_OR:  alu_res = a | b_val;
      OP_XOR: alu_res = a ^ b_val;
      OP_SHL: alu_res = a << shamt;
      OP_SHR: alu_res = a >> shamt;
      OP_SRA: alu_res = $signed(a) >>> shamt;
      OP_LTU: alu_res = DATA_WIDTH'(a < b_val);
      OP_LTS: alu_res = DATA_WIDTH'($signed(a) < $signed(b_val));
      OP_EQ:  alu_res = DATA_WIDTH'(a == b_val);
      default: alu_res = '0;
    endcase
  end

  // Fire decision, consumed channels, result select and carry FSM next state
  always_comb begin
    req     = '0;
    fire    = 1'b0;
    produce = 1'b0;
    mul_go  = 1'b0;
    res     = alu_res;
    carry_d = carry_q;
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SRA,
      OP_LTU, OP_LTS, OP_EQ: begin
        req[CH_A] = 1'b1;
        req[CH_B] = ~imm_en_q;
        fire      = can_fire & a_v & b_ok;
        produce   = fire;
      end
      OP_MUL: begin
        req[CH_A] = 1'b1;
        req[CH_B] = ~imm_en_q;
        fire      = can_fire & a_v & b_ok;
        mul_go    = fire;
      end
      OP_STEERT, OP_STEERF: begin
        req[CH_A] = 1'b1;
        req[CH_D] = 1'b1;
        fire      = can_fire & a_v & d_v;
        res       = a;
        // A passes only when the decider matches the steer polarity
        produce   = fire & (d_sel == (op_q == OP_STEERT));
      end
      OP_MERGE: begin
        req[CH_D] = 1'b1;
        req[CH_A] = d_sel;
        req[CH_B] = ~d_sel & ~imm_en_q;
        fire      = can_fire & d_v & (d_sel ? a_v : b_ok);
        res       = d_sel ? a : b_val;
        produce   = fire;
      end
      OP_CARRY: begin
        if (carry_q == CARRY_INIT) begin
          req[CH_A] = 1'b1;
          fire      = can_fire & a_v;
          res       = a;
          produce   = fire;
          if (fire) carry_d = CARRY_LOOP;
        end else begin
          req[CH_D] = 1'b1;
          req[CH_B] = d_sel & ~imm_en_q;
          fire      = can_fire & d_v & (~d_sel | b_ok);
          res       = b_val;
          produce   = fire & d_sel;
          if (fire & ~d_sel) carry_d = CARRY_INIT;
        end
      end
      default: ;
    endcase
    if (clear | cfg_accept) carry_d = CARRY_INIT;
  end

  pe_fu_mul_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .MUL_LAT   (MUL_LAT)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .in_valid (mul_go),
    .a        (a),
    .b        (b_val),
    .res_valid(mul_res_valid),
    .res_data (mul_res_data),
    .busy     (mul_busy)
  );

  // Config and output register next state; clear wins over everything but keeps config
  always_comb begin
    op_d       = op_q;
    imm_en_d   = imm_en_q;
    imm_d      = imm_q;
    cfgd_d     = cfgd_q;
    fu_valid_d = fu_valid_q;
    fu_out_d   = fu_out_q;
    if (cfg_accept) begin
      op_d     = fu_op_e'(cfg_op);
      imm_en_d = cfg_imm_en;
      imm_d    = cfg_imm;
      cfgd_d   = 1'b1;
    end
    if (clear) begin
      fu_valid_d = 1'b0;
    end else begin
      if (fu_valid_q & out_ready) fu_valid_d = 1'b0;
      if (produce) begin
        fu_valid_d = 1'b1;
        fu_out_d   = res;
      end else if (mul_res_valid) begin
        fu_valid_d = 1'b1;
        fu_out_d   = mul_res_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_NOP;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      cfgd_q     <= 1'b0;
      carry_q    <= CARRY_INIT;
      fu_valid_q <= 1'b0;
      fu_out_q   <= '0;
    end else begin
      op_q       <= op_d;
      imm_en_q   <= imm_en_d;
      imm_q      <= imm_d;
      cfgd_q     <= cfgd_d;
      carry_q    <= carry_d;
      fu_valid_q <= fu_valid_d;
      fu_out_q   <= fu_out_d;
    end
  end

  assign cfgd     = cfgd_q;
  assign fu_valid = fu_valid_q;
  assign fu_out   = fu_out_q;
  assign fu_ready = req & {3{fire}};
  assign fu_alloc = produce | mul_go;
  assign fu_done  = fu_valid_q & out_ready & ~clear;

endmodule

// File: tb/tb_pe_fu_dfx.sv
// Directed bench for pe_fu_dfx: opcode vector table plus hand sequences for
// streaming, backpressure, multiply latency, carry, clear and async reset.
module tb_pe_fu_dfx;
  import pe_fu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [4:0]  cfg_op;
  logic        cfg_imm_en;
  logic [31:0] cfg_imm;
  logic        cfgd;
  logic        clear;
  logic [2:0]  in_valid;
  logic [95:0] in_data;
  logic [2:0]  fu_ready;
  logic        out_ready;
  logic [31:0] fu_out;
  logic        fu_valid;
  logic        fu_alloc;
  logic        fu_done;

  int total = 0;
  int bad   = 0;

  pe_fu_dfx #(.DATA_WIDTH(32), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_op(cfg_op),
    .cfg_imm_en(cfg_imm_en), .cfg_imm(cfg_imm), .cfgd(cfgd), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .fu_ready(fu_ready),
    .out_ready(out_ready), .fu_out(fu_out), .fu_valid(fu_valid),
    .fu_alloc(fu_alloc), .fu_done(fu_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    fu_op_e      op;
    logic        imm_en;
    logic [31:0] imm;
    logic [2:0]  vld;
    logic [31:0] a, b, d;
    logic [2:0]  e_rdy;
    logic        e_alloc;
    logic        e_valid;
    logic [31:0] e_out;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d);
    in_valid = v;
    in_data  = {d, b, a};
  endtask

  task automatic configure(input fu_op_e op, input logic imm_en, input logic [31:0] imm);
    in_valid   = '0;
    cfg_valid  = 1'b1;
    cfg_op     = op;
    cfg_imm_en = imm_en;
    cfg_imm    = imm;
    tick();
    cfg_valid  = 1'b0;
  endtask

  initial begin
    //                op         ie   imm    vld     a             b             d      rdy     al    v     out
    tv[0]  = '{OP_ADD,    1'b0, 32'd0,  3'b011, 32'hFFFF_FFFF, 32'd2,        32'd0, 3'b011, 1'b1, 1'b1, 32'd1};
    tv[1]  = '{OP_SUB,    1'b0, 32'd0,  3'b011, 32'd3,         32'd5,        32'd0, 3'b011, 1'b1, 1'b1, 32'hFFFF_FFFE};
    tv[2]  = '{OP_AND,    1'b0, 32'd0,  3'b011, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 3'b011, 1'b1, 1'b1, 32'h0000_F000};
    tv[3]  = '{OP_OR,     1'b0, 32'd0,  3'b011, 32'h0000_00F0, 32'h0000_000F, 32'd0, 3'b011, 1'b1, 1'b1, 32'h0000_00FF};
    tv[4]  = '{OP_XOR,    1'b0, 32'd0,  3'b011, 32'h0000_00FF, 32'h0000_000F, 32'd0, 3'b011, 1'b1, 1'b1, 32'h0000_00F0};
    tv[5]  = '{OP_SHL,    1'b0, 32'd0,  3'b011, 32'd1,         32'd33,       32'd0, 3'b011, 1'b1, 1'b1, 32'd2};
    tv[6]  = '{OP_SHR,    1'b0, 32'd0,  3'b011, 32'h8000_0000, 32'd4,        32'd0, 3'b011, 1'b1, 1'b1, 32'h0800_0000};
    tv[7]  = '{OP_SRA,    1'b0, 32'd0,  3'b011, 32'h8000_0000, 32'd4,        32'd0, 3'b011, 1'b1, 1'b1, 32'hF800_0000};
    tv[8]  = '{OP_LTU,    1'b0, 32'd0,  3'b011, 32'd1,         32'hFFFF_FFFF, 32'd0, 3'b011, 1'b1, 1'b1, 32'd1};
    tv[9]  = '{OP_LTS,    1'b0, 32'd0,  3'b011, 32'd1,         32'hFFFF_FFFF, 32'd0, 3'b011, 1'b1, 1'b1, 32'd0};
    tv[10] = '{OP_EQ,     1'b0, 32'd0,  3'b011, 32'd5,         32'd5,        32'd0, 3'b011, 1'b1, 1'b1, 32'd1};
    tv[11] = '{OP_ADD,    1'b1, 32'd10, 3'b011, 32'd5,         32'd99,       32'd0, 3'b001, 1'b1, 1'b1, 32'd15};
    tv[12] = '{OP_STEERT, 1'b0, 32'd0,  3'b101, 32'd5,         32'd0,        32'd0, 3'b101, 1'b0, 1'b0, 32'd0};
    tv[13] = '{OP_STEERT, 1'b0, 32'd0,  3'b101, 32'd9,         32'd0,        32'd1, 3'b101, 1'b1, 1'b1, 32'd9};
    tv[14] = '{OP_STEERF, 1'b0, 32'd0,  3'b101, 32'd7,         32'd0,        32'd0, 3'b101, 1'b1, 1'b1, 32'd7};
    tv[15] = '{OP_MERGE,  1'b0, 32'd0,  3'b111, 32'd11,        32'd22,       32'd1, 3'b101, 1'b1, 1'b1, 32'd11};
    tv[16] = '{OP_MERGE,  1'b0, 32'd0,  3'b110, 32'd11,        32'd22,       32'd0, 3'b110, 1'b1, 1'b1, 32'd22};
    tv[17] = '{OP_MERGE,  1'b0, 32'd0,  3'b011, 32'd11,        32'd22,       32'd0, 3'b000, 1'b0, 1'b0, 32'd0};
    tv[18] = '{OP_ADD,    1'b0, 32'd0,  3'b001, 32'd1,         32'd1,        32'd0, 3'b000, 1'b0, 1'b0, 32'd0};
    tv[19] = '{OP_NOP,    1'b0, 32'd0,  3'b111, 32'd1,         32'd1,        32'd1, 3'b000, 1'b0, 1'b0, 32'd0};
    tv[20] = '{OP_STEERF, 1'b0, 32'd0,  3'b101, 32'd4,         32'd0,        32'd1, 3'b101, 1'b0, 1'b0, 32'd0};
    tv[21] = '{OP_LTS,    1'b0, 32'd0,  3'b011, 32'hFFFF_FFFE, 32'd1,        32'd0, 3'b011, 1'b1, 1'b1, 32'd1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_op = '0; cfg_imm_en = 1'b0; cfg_imm = '0;
    clear = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(3'b111, 32'd1, 32'd1, 32'd1);
    #1;
    chk("reset.cfgd", 32'(cfgd), 32'd0);
    chk("reset.fu_ready", 32'(fu_ready), 32'd0);
    chk("reset.fu_valid", 32'(fu_valid), 32'd0);
    chk("reset.fu_alloc", 32'(fu_alloc), 32'd0);
    chk("reset.fu_done", 32'(fu_done), 32'd0);
    chk("reset.fu_out", fu_out, 32'd0);

    // Config ADD arms the unit one cycle later
    configure(OP_ADD, 1'b0, 32'd0);
    chk("cfg.cfgd", 32'(cfgd), 32'd1);

    // Opcode table: fire one vector, check handshake, then the registered result
    for (int i = 0; i < NV; i++) begin
      configure(tv[i].op, tv[i].imm_en, tv[i].imm);
      out_ready = 1'b1;
      drive(tv[i].vld, tv[i].a, tv[i].b, tv[i].d);
      #1;
      chk($sformatf("vec%0d.rdy", i), 32'(fu_ready), 32'(tv[i].e_rdy));
      chk($sformatf("vec%0d.alloc", i), 32'(fu_alloc), 32'(tv[i].e_alloc));
      tick();
      in_valid = '0;
      #1;
      chk($sformatf("vec%0d.valid", i), 32'(fu_valid), 32'(tv[i].e_valid));
      if (tv[i].e_valid) chk($sformatf("vec%0d.out", i), fu_out, tv[i].e_out);
      tick();
    end

    // ADD stream: four back-to-back pairs, one result per cycle
    configure(OP_ADD, 1'b0, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(3'b011, 32'(k * 10 + 1), 32'(k + 100), 32'd0);
      #1;
      chk($sformatf("stream%0d.rdy", k), 32'(fu_ready), 32'd3);
      if (k > 0) begin
        chk($sformatf("stream%0d.valid", k), 32'(fu_valid), 32'd1);
        chk($sformatf("stream%0d.out", k), fu_out, 32'((k - 1) * 10 + 1 + (k - 1) + 100));
        chk($sformatf("stream%0d.done", k), 32'(fu_done), 32'd1);
      end
      tick();
    end
    in_valid = '0;
    #1;
    chk("stream.last", fu_out, 32'd134);
    tick();

    // Backpressure: result held, no further consumption, cfg while busy ignored
    out_ready = 1'b0;
    drive(3'b011, 32'd1, 32'd2, 32'd0);
    #1;
    chk("bp.fire", 32'(fu_ready), 32'd3);
    tick();
    drive(3'b011, 32'd5, 32'd3, 32'd0);
    #1;
    chk("bp.hold_valid", 32'(fu_valid), 32'd1);
    chk("bp.hold_out", fu_out, 32'd3);
    chk("bp.stall_rdy", 32'(fu_ready), 32'd0);
    chk("bp.no_done", 32'(fu_done), 32'd0);
    cfg_valid = 1'b1; cfg_op = OP_SUB; cfg_imm_en = 1'b0;
    tick();
    cfg_valid = 1'b0;
    #1;
    chk("bp.hold_out2", fu_out, 32'd3);
    out_ready = 1'b1;
    #1;
    chk("bp.drain_done", 32'(fu_done), 32'd1);
    chk("bp.refire", 32'(fu_ready), 32'd3);
    tick();
    in_valid = '0;
    #1;
    chk("bp.cfg_ignored", fu_out, 32'd8);
    tick();

    // MUL latency 3 and blocking of new operands while in flight
    configure(OP_MUL, 1'b0, 32'd0);
    out_ready = 1'b1;
    drive(3'b011, 32'd7, 32'd6, 32'd0);
    #1;
    chk("mul.fire_rdy", 32'(fu_ready), 32'd3);
    chk("mul.alloc", 32'(fu_alloc), 32'd1);
    for (int t = 1; t <= 2; t++) begin
      tick();
      #1;
      chk($sformatf("mul.t%0d.rdy", t), 32'(fu_ready), 32'd0);
      chk($sformatf("mul.t%0d.valid", t), 32'(fu_valid), 32'd0);
    end
    tick();
    in_valid = '0;
    #1;
    chk("mul.t3.valid", 32'(fu_valid), 32'd1);
    chk("mul.t3.out", fu_out, 32'd42);
    chk("mul.t3.done", 32'(fu_done), 32'd1);
    tick();

    // CARRY: A seeds, D=1 loops B, D=0 returns to INIT leaving B
    configure(OP_CARRY, 1'b0, 32'd0);
    out_ready = 1'b1;
    drive(3'b011, 32'd1, 32'd2, 32'd0);
    #1;
    chk("carry.init_rdy", 32'(fu_ready), 32'd1);
    chk("carry.init_alloc", 32'(fu_alloc), 32'd1);
    tick();
    drive(3'b111, 32'd3, 32'd2, 32'd1);
    #1;
    chk("carry.out1", fu_out, 32'd1);
    chk("carry.loop_rdy", 32'(fu_ready), 32'd6);
    tick();
    drive(3'b111, 32'd3, 32'd2, 32'd0);
    #1;
    chk("carry.out2", fu_out, 32'd2);
    chk("carry.exit_rdy", 32'(fu_ready), 32'd4);
    chk("carry.exit_alloc", 32'(fu_alloc), 32'd0);
    tick();
    drive(3'b011, 32'd3, 32'd2, 32'd0);
    #1;
    chk("carry.exit_novalid", 32'(fu_valid), 32'd0);
    chk("carry.reinit_rdy", 32'(fu_ready), 32'd1);
    tick();
    in_valid = '0;
    #1;
    chk("carry.out3", fu_out, 32'd3);
    tick();

    // clear with a pending output: no fu_done, no fire, output gone next cycle
    configure(OP_ADD, 1'b0, 32'd0);
    out_ready = 1'b0;
    drive(3'b011, 32'd1, 32'd1, 32'd0);
    tick();
    clear = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("clr.pend_done", 32'(fu_done), 32'd0);
    chk("clr.pend_rdy", 32'(fu_ready), 32'd0);
    tick();
    clear = 1'b0;
    in_valid = '0;
    #1;
    chk("clr.pend_valid", 32'(fu_valid), 32'd0);
    chk("clr.cfg_kept", 32'(cfgd), 32'd1);
    tick();

    // clear with MUL in flight: result never appears
    configure(OP_MUL, 1'b0, 32'd0);
    out_ready = 1'b1;
    drive(3'b011, 32'd7, 32'd6, 32'd0);
    tick();
    in_valid = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk($sformatf("clr.mul%0d.valid", t), 32'(fu_valid), 32'd0);
      tick();
    end
    configure(OP_ADD, 1'b0, 32'd0);
    drive(3'b011, 32'd1, 32'd1, 32'd0);
    #1;
    chk("clr.add_rdy", 32'(fu_ready), 32'd3);
    tick();
    in_valid = '0;
    #1;
    chk("clr.add_valid", 32'(fu_valid), 32'd1);
    chk("clr.add_out", fu_out, 32'd2);
    tick();

    // Async reset mid-MUL wipes result and configuration
    configure(OP_MUL, 1'b0, 32'd0);
    drive(3'b011, 32'd3, 32'd3, 32'd0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst.cfgd", 32'(cfgd), 32'd0);
    chk("rst.fu_valid", 32'(fu_valid), 32'd0);
    chk("rst.fu_out", fu_out, 32'd0);
    chk("rst.fu_ready", 32'(fu_ready), 32'd0);
    chk("rst.fu_alloc", 32'(fu_alloc), 32'd0);
    chk("rst.fu_done", 32'(fu_done), 32'd0);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("rst.after%0d.valid", t), 32'(fu_valid), 32'd0);
    end
    chk("rst.after.ready", 32'(fu_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
